// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32I hazard unit: result-select codes, forwarding-mux selects and memory-wait states.
package hazard_pkg;
  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_LOAD  = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_AUIPC = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_e;

  // M-stage result is younger than W-stage, so it takes priority; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic wr_m, input logic [4:0] rd_m,
                                         input logic wr_w, input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return FWD_MEM;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return FWD_WB;
    else                                         return FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait tracker: holds the pipeline while an M-stage access is pending, with a watchdog
// that gives up after MEM_TIMEOUT wait cycles and raises a sticky error.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  mem_state_e    state;
  logic [CW-1:0] cnt;
  logic          timed_out;

  assign timed_out = (state == MEM_WAIT) && (cnt == CW'(MEM_TIMEOUT));

  // Ready and timeout both release the pipeline in the cycle they occur.
  assign mem_stall = (state == MEM_IDLE && mem_req && !mem_ready) ||
                     (state == MEM_WAIT && !mem_ready && !timed_out);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MEM_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (mem_req && !mem_ready) begin
            state <= MEM_WAIT;
            cnt   <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= MEM_IDLE;
          end else if (timed_out) begin
            state   <= MEM_IDLE;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/control unit for the 5-stage RV32I pipeline: forwarding, load-use stall, branch flush, memory waits.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);
  logic lw_stall, mem_stall, mem_err;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (hz.MemReqM),
    .mem_ready(hz.MemReadyM),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  assign lw_stall = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != 5'd0) &&
                    (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

  always_comb begin
    fwd_a   = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
    fwd_b   = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
    stall_f = lw_stall;
    stall_d = lw_stall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = hz.PCSrcE;
    flush_e = lw_stall | hz.PCSrcE;
    flush_w = 1'b0;
    if (!rst_n) begin
      fwd_a   = FWD_REG;
      fwd_b   = FWD_REG;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to M and bubble W; a taken branch in E is simply held and resolved later.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b1;
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_d | flush_e) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`else
  assign hz.StallCnt = '0;
  assign hz.FlushCnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_ctrl;
  localparam int TO    = 16;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Model state: cycles spent waiting on the current access (0 = no outstanding wait).
  int      waited;
  bit      err_m;
  longint  scnt_m, fcnt_m;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (bus.RegWriteM && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
  function automatic logic [11:0] ref_out();
    bit memst, lw;
    if (!rst_n) return {4'b0000, 4'b0000, 3'b111, err_m};
    if (waited == 0) memst = bus.MemReqM && !bus.MemReadyM;
    else             memst = !bus.MemReadyM && waited < TO;
    lw = bus.ResultSrcE == 2'b01 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    if (memst) return {ref_fwd(bus.Rs1E), ref_fwd(bus.Rs2E), 4'b1111, 3'b001, err_m};
    return {ref_fwd(bus.Rs1E), ref_fwd(bus.Rs2E), lw, lw, 2'b00, bus.PCSrcE, lw | bus.PCSrcE, 1'b0, err_m};
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
            bus.FlushD, bus.FlushE, bus.FlushW, bus.MemErr};
  endfunction

  function automatic logic [63:0] ref_cnts();
    if (!PERF) return 64'd0;
    return {32'(scnt_m), 32'(fcnt_m)};
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    logic [11:0] e;
    e = ref_out();
    @(posedge clk);
    if (!rst_n) begin
      waited = 0; err_m = 0; scnt_m = 0; fcnt_m = 0;
    end else begin
      if (e[7] && scnt_m < 64'hFFFF_FFFF) scnt_m++;
      if ((e[3] | e[2]) && fcnt_m < 64'hFFFF_FFFF) fcnt_m++;
      if (waited == 0) begin
        if (bus.MemReqM && !bus.MemReadyM) waited = 1;
      end else if (bus.MemReadyM) waited = 0;
      else if (waited == TO) begin waited = 0; err_m = 1; end
      else waited++;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.RdE = 0; bus.RdM = 0; bus.RdW = 0; bus.ResultSrcE = 2'b00;
    bus.RegWriteM = 0; bus.RegWriteW = 0; bus.PCSrcE = 0;
    bus.MemReqM = 0; bus.MemReadyM = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    bus.RegWriteM = 1; bus.RdM = 3; bus.Rs1E = 3; bus.MemReqM = 1; bus.MemReadyM = 0;
    tick(); tick();
    checks++;
    if (dut_out() !== 12'b0000_0000_1110) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", dut_out(), 12'b0000_0000_1110);
    end
    checks++;
    if ({bus.StallCnt, bus.FlushCnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters got %h exp 0", {bus.StallCnt, bus.FlushCnt});
    end
    clear_inputs();
    rst_n = 1;
    #1;
    checks++;
    if (dut_out() !== 12'd0) begin
      errors++; $display("FAIL reset_release got %b exp %b", dut_out(), 12'd0);
    end
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    bus.RdM = 5; bus.RegWriteM = 1; bus.Rs1E = 5; bus.RdW = 5; bus.RegWriteW = 1;
    #1; checks++;
    if (bus.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_wins got %b exp 10", bus.ForwardAE); end
    bus.RegWriteM = 0;
    #1; checks++;
    if (bus.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got %b exp 01", bus.ForwardAE); end
    bus.RegWriteM = 1; bus.RdM = 0; bus.RdW = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    #1; checks++;
    if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got %b exp 0000", {bus.ForwardAE, bus.ForwardBE});
    end
    tick();
    for (int i = 0; i < 40; i++) begin
      bus.Rs1E = 5'($urandom_range(0, 3)); bus.Rs2E = 5'($urandom_range(0, 3));
      bus.RdM = 5'($urandom_range(0, 3));  bus.RdW = 5'($urandom_range(0, 3));
      bus.RegWriteM = 1'($urandom_range(0, 1)); bus.RegWriteW = 1'($urandom_range(0, 1));
      #1; checks++;
      if (dut_out() !== ref_out()) begin
        errors++; $display("FAIL fwd_rand[%0d] got %b exp %b", i, dut_out(), ref_out());
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7; bus.Rs1D = 2;
    #1; checks++;
    if ({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD} !== 4'b1110) begin
      errors++; $display("FAIL lw_stall got %b exp 1110", {bus.StallF, bus.StallD, bus.FlushE, bus.FlushD});
    end
    tick();
    // Bubble now in E: the stall must not repeat.
    bus.ResultSrcE = 2'b00; bus.RdE = 0;
    #1; checks++;
    if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin
      errors++; $display("FAIL lw_one_cycle got %b exp 000", {bus.StallF, bus.StallD, bus.FlushE});
    end
    tick();
    bus.ResultSrcE = 2'b01; bus.RdE = 0; bus.Rs1D = 0; bus.Rs2D = 0;
    #1; checks++;
    if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin
      errors++; $display("FAIL lw_rd_x0 got %b exp 000", {bus.StallF, bus.StallD, bus.FlushE});
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.PCSrcE = 1;
    #1; checks++;
    if ({bus.FlushD, bus.FlushE, bus.StallF} !== 3'b110) begin
      errors++; $display("FAIL branch_flush got %b exp 110", {bus.FlushD, bus.FlushE, bus.StallF});
    end
    tick();
    bus.ResultSrcE = 2'b01; bus.RdE = 9; bus.Rs1D = 9;
    #1; checks++;
    if ({bus.FlushD, bus.FlushE, bus.StallF, bus.StallD} !== 4'b1111) begin
      errors++; $display("FAIL branch_and_lw got %b exp 1111", {bus.FlushD, bus.FlushE, bus.StallF, bus.StallD});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    bus.MemReqM = 1; bus.MemReadyM = 0; bus.PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if ({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW, bus.FlushD, bus.FlushE} !== 7'b1111100) begin
        errors++; $display("FAIL mem_wait[%0d] got %b exp 1111100", i,
          {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW, bus.FlushD, bus.FlushE});
      end
      tick();
    end
    bus.MemReadyM = 1; bus.PCSrcE = 0;
    #1; checks++;
    if ({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW, bus.MemErr} !== 6'b0) begin
      errors++; $display("FAIL mem_ready got %b exp 000000",
        {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW, bus.MemErr});
    end
    tick();
  endtask

  task automatic test_timeout();
    int stalled;
    bit released;
    clear_inputs();
    stalled = 0; released = 0;
    bus.MemReqM = 1; bus.MemReadyM = 0;
    for (int i = 0; i < 40 && !released; i++) begin
      #1;
      if (bus.StallM === 1'b1) stalled++;
      else released = 1;
      if (!released) tick();
    end
    checks++;
    if (!released || stalled != TO) begin
      errors++; $display("FAIL timeout_len got %0d stalled (released=%0d) exp %0d", stalled, released, TO);
    end
    tick();
    bus.MemReqM = 0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (dut_out() !== ref_out() || bus.MemErr !== 1'b1) begin
        errors++; $display("FAIL memerr_sticky[%0d] got %b exp %b", i, dut_out(), ref_out());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    bus.MemReqM = 1; bus.MemReadyM = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    #1; checks++;
    if (dut_out() !== 12'b0000_0000_1110) begin
      errors++; $display("FAIL rst_in_wait got %b exp %b", dut_out(), 12'b0000_0000_1110);
    end
    checks++;
    if ({bus.StallCnt, bus.FlushCnt} !== 64'd0) begin
      errors++; $display("FAIL rst_counters got %h exp 0", {bus.StallCnt, bus.FlushCnt});
    end
    rst_n = 1; bus.MemReqM = 0;
    #1; checks++;
    if (dut_out() !== 12'd0) begin
      errors++; $display("FAIL rst_wait_idle got %b exp %b", dut_out(), 12'd0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.Rs1D = 5'($urandom_range(0, 7)); bus.Rs2D = 5'($urandom_range(0, 7));
      bus.Rs1E = 5'($urandom_range(0, 7)); bus.Rs2E = 5'($urandom_range(0, 7));
      bus.RdE  = 5'($urandom_range(0, 7)); bus.RdM  = 5'($urandom_range(0, 7));
      bus.RdW  = 5'($urandom_range(0, 7)); bus.ResultSrcE = 2'($urandom_range(0, 3));
      bus.RegWriteM = 1'($urandom_range(0, 1)); bus.RegWriteW = 1'($urandom_range(0, 1));
      bus.PCSrcE  = ($urandom_range(0, 3) == 0);
      bus.MemReqM = 1'($urandom_range(0, 1));
      bus.MemReadyM = (i % 60 < 25) ? 1'b0 : ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      #1; checks++;
      if (dut_out() !== ref_out()) begin
        errors++; $display("FAIL rand_out[%0d] got %b exp %b", i, dut_out(), ref_out());
      end
      checks++;
      if ({bus.StallCnt, bus.FlushCnt} !== ref_cnts()) begin
        errors++; $display("FAIL rand_cnt[%0d] got %h exp %h", i, {bus.StallCnt, bus.FlushCnt}, ref_cnts());
      end
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    waited = 0; err_m = 0; scnt_m = 0; fcnt_m = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
